// File: rtl/repsub_divider.sv
// repsub_divider: sequential unsigned divider using repeated subtraction.
// A small FSM loads the dividend and divisor serially over one bus. It then
// subtracts the divisor from the running remainder until the remainder is
// smaller than the divisor, counting one per subtraction.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   begin a division (sampled in IDLE/DONE only)
//   data_in   in   WIDTH  dividend (cycle after start edge), then divisor
//   quotient  out  WIDTH  Q register, qualify with done
//   remainder out  WIDTH  A register, qualify with done
//   done      out  result valid, held in DONE
//   busy      out  high in LOAD_A, LOAD_B, SUB
//   div_zero  out  last divisor was zero, qualify with done
module repsub_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_zero
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_SUB    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dz_q, dz_d;
  logic             a_ge_b;

  assign a_ge_b = (a_q >= b_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        a_d     = data_in;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        b_d  = data_in;
        q_d  = '0;
        dz_d = (data_in == '0);
        // Zero divisor skips SUB entirely: remainder stays the dividend.
        state_d = (data_in == '0) ? S_DONE : S_SUB;
      end
      S_SUB: begin
        // Subtract only while A >= B, so A never underflows and Q never
        // exceeds the dividend.
        if (a_ge_b) begin
          a_d = a_q - b_q;
          q_d = q_q + 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) state_d = S_LOAD_A;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      dz_q    <= dz_d;
    end
  end

  assign quotient  = q_q;
  assign remainder = a_q;
  assign div_zero  = dz_q;
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) ||
                     (state_q == S_SUB);

endmodule

// File: tb/tb_repsub_divider.sv
module tb_repsub_divider;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_zero;

  repsub_divider #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .quotient (quotient),
    .remainder(remainder),
    .done     (done),
    .busy     (busy),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter used to measure latency from the start edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int q;
    int r;
    int dz;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   e0_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives start at e0, dividend after e0, divisor after e1. Returns with the
  // divisor on the bus in the cycle before e2.
  task automatic launch(input int d, input int v, input bit push);
    exp_t e;
    @(negedge clk);
    start  = 1'b1;
    e0_cnt = cyc;
    if (push) begin
      if (v == 0) begin
        e.q = 0; e.r = d; e.dz = 1; e.lat = 2;
      end else begin
        e.q = d / v; e.r = d % v; e.dz = 0; e.lat = d / v + 3;
      end
      sb.push_back(e);
    end
    @(negedge clk);
    start   = 1'b0;
    data_in = d[WIDTH-1:0];
    chk("busy_after_e0", {31'b0, busy}, 32'd1);
    chk("done_after_e0", {31'b0, done}, 32'd0);
    @(negedge clk);
    data_in = v[WIDTH-1:0];
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    bit   got     = 1'b0;
    bit   busy_ok = 1'b1;
    int   lat;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      data_in = '0;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    lat = cyc - e0_cnt - 1;
    chk({tag, "_finished"}, {31'b0, got}, 32'd1);
    chk({tag, "_busy_held"}, {31'b0, busy_ok}, 32'd1);
    chk({tag, "_no_overlap"}, {31'b0, done & busy}, 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_quotient"}, {24'b0, quotient}, e.q);
      chk({tag, "_remainder"}, {24'b0, remainder}, e.r);
      chk({tag, "_div_zero"}, {31'b0, div_zero}, e.dz);
      chk({tag, "_latency"}, lat, e.lat);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_quotient"}, {24'b0, quotient}, 32'd0);
    chk({tag, "_remainder"}, {24'b0, remainder}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_div_zero"}, {31'b0, div_zero}, 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Basic division.
    launch(26, 10, 1'b1);
    wait_done("div_26_10");

    // Dividend smaller than divisor, then equal.
    launch(10, 26, 1'b1);
    wait_done("div_10_26");
    launch(10, 10, 1'b1);
    wait_done("div_10_10");

    // Maximum quotient and zero dividend.
    launch(255, 1, 1'b1);
    wait_done("div_255_1");
    launch(0, 5, 1'b1);
    wait_done("div_0_5");

    // Divide by zero, then a normal division clears div_zero.
    launch(7, 0, 1'b1);
    wait_done("div_7_0");
    launch(9, 3, 1'b1);
    wait_done("div_9_3");

    // Reset in the middle of SUB: raise rst so it is sampled at e10.
    launch(200, 3, 1'b0);
    while (cyc < e0_cnt + 10) @(negedge clk);
    data_in = '0;
    rst     = 1'b1;
    @(negedge clk);
    chk_zero("midreset");
    rst = 1'b0;
    @(negedge clk);
    chk({"midreset_idle_busy"}, {31'b0, busy}, 32'd0);
    launch(26, 10, 1'b1);
    wait_done("after_reset");

    // Start pulsed during SUB is ignored.
    launch(100, 7, 1'b1);
    repeat (5) @(negedge clk);
    data_in = '0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("div_100_7");

    // Back-to-back from DONE; launch checks done drops after e0.
    launch(50, 8, 1'b1);
    wait_done("div_50_8");

    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
